// File: rtl/prog_loader_if.sv
// Stream-in / memory-write-out bundle for the boot loader.
// Latency: n/a (wires only).
// Backpressure: rx_ready is owned by the loader; the memory side never stalls.
//
// Signals:
//   rx_data/rx_valid/rx_ready  byte stream, consumed on rx_valid && rx_ready
//   mem_we                     single-cycle write strobe
//   mem_sel                    0 = instruction memory, 1 = data memory
//   mem_addr/mem_wdata         word address and write word
// Modports:
//   master  the loader's view (consumes the stream, drives the write port)
//   slave   the environment's view (byte source plus memory write sink)
interface prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_sel,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_sel,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses framed byte stream, writes 32-bit words to IMEM/DMEM, then releases the core.
// Latency: mem_we one cycle after the 4th byte of a word; done/err one cycle after the deciding byte.
// Backpressure: accepts one byte per cycle while parsing; rx_ready drops for good in RUN or ERR.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   bus      prog_loader_if.master: rx stream in, memory write port out
//   cpu_rst  active-high reset to the processor core, released by RUN
//   done     RUN accepted, core released
//   err      sticky protocol/checksum error
//
// Frame: 0xA0/0xA1, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, CNT*4 data bytes (LE words), CSUM.
//        0xFF alone is RUN. CSUM is the XOR of every byte from the command through the last data byte.
// Requires ADDR_W <= 16; only the low ADDR_W bits of the 16-bit frame address are kept.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    prog_loader_if.master   bus,
    output logic            cpu_rst,
    output logic            done,
    output logic            err
);

    localparam logic [7:0] CMD_IMEM = 8'hA0;
    localparam logic [7:0] CMD_DMEM = 8'hA1;
    localparam logic [7:0] CMD_RUN  = 8'hFF;

    typedef enum logic [3:0] {
        S_CMD,
        S_ADDR0,
        S_ADDR1,
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic              rx_ready_q;
    logic              rdy_nx;
    logic              acc;
    logic [7:0]        rxd;
    logic              is_load;
    logic [15:0]       cnt_in;

    logic [7:0]        addr_lo;
    logic [7:0]        cnt_lo;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       cnt_r;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;

    logic              mem_we_q;
    logic              mem_sel_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    // FSM strobes
    logic              csum_upd;
    logic              csum_clr;
    logic              wr_word;

    assign rxd     = bus.rx_data;
    assign acc     = bus.rx_valid && rx_ready_q;
    assign is_load = (rxd == CMD_IMEM) || (rxd == CMD_DMEM);
    assign cnt_in  = {rxd, cnt_lo};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CMD;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and strobes. Nothing moves unless a byte is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        csum_upd = 1'b0;
        csum_clr = 1'b0;
        wr_word  = 1'b0;

        if (acc) begin
            case (state)
                S_CMD: begin
                    if (is_load) begin
                        state_nx = S_ADDR0;
                        csum_upd = 1'b1;
                    end else if (rxd == CMD_RUN) begin
                        state_nx = S_RUN;
                    end else begin
                        state_nx = S_ERR;
                    end
                end
                S_ADDR0: begin
                    state_nx = S_ADDR1;
                    csum_upd = 1'b1;
                end
                S_ADDR1: begin
                    state_nx = S_CNT0;
                    csum_upd = 1'b1;
                end
                S_CNT0: begin
                    state_nx = S_CNT1;
                    csum_upd = 1'b1;
                end
                S_CNT1: begin
                    csum_upd = 1'b1;
                    // An empty frame skips straight to its checksum byte.
                    state_nx = (cnt_in == 16'd0) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    csum_upd = 1'b1;
                    if (byte_idx == 2'd3) begin
                        wr_word = 1'b1;
                        if (cnt_r == 16'd1) begin
                            state_nx = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (rxd == csum) begin
                        state_nx = S_CMD;
                        csum_clr = 1'b1;
                    end else begin
                        state_nx = S_ERR;
                    end
                end
                default: begin
                    // RUN and ERR are terminal; rx_ready is low there anyway.
                    state_nx = state;
                end
            endcase
        end

        // rx_ready is registered from the next state so it drops in the
        // same cycle that done/err rise.
        rdy_nx = (state_nx != S_RUN) && (state_nx != S_ERR);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            addr_lo     <= 8'd0;
            cnt_lo      <= 8'd0;
            addr_r      <= '0;
            cnt_r       <= 16'd0;
            byte_idx    <= 2'd0;
            word_buf    <= 24'd0;
            csum        <= 8'd0;
        end else begin
            rx_ready_q <= rdy_nx;
            mem_we_q   <= wr_word;

            if (csum_clr) begin
                csum <= 8'd0;
            end else if (csum_upd) begin
                csum <= csum ^ rxd;
            end

            if (acc) begin
                case (state)
                    S_CMD: begin
                        if (is_load) begin
                            mem_sel_q <= rxd[0];
                        end
                    end
                    S_ADDR0: addr_lo <= rxd;
                    S_ADDR1: addr_r  <= ADDR_W'({rxd, addr_lo});
                    S_CNT0:  cnt_lo  <= rxd;
                    S_CNT1: begin
                        cnt_r    <= cnt_in;
                        byte_idx <= 2'd0;
                    end
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rxd;
                            2'd1: word_buf[15:8]  <= rxd;
                            2'd2: word_buf[23:16] <= rxd;
                            default: begin
                                // Word complete: present it for the one-cycle strobe.
                                // addr/wdata then hold until the next word.
                                mem_wdata_q <= {rxd, word_buf};
                                mem_addr_q  <= addr_r;
                                addr_r      <= addr_r + ADDR_W'(1);
                                cnt_r       <= cnt_r - 16'd1;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign cpu_rst = (state != S_RUN);
    assign done    = (state == S_RUN);
    assign err     = (state == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of whole frames plus hand sequences for
// terminal states and asynchronous reset in the middle of a frame.
// Expected memory writes are queued when a frame is driven and checked when mem_we fires.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_rst;
    logic done;
    logic err;

    prog_loader_if #(.ADDR_W(10)) bus ();

    prog_loader #(.ADDR_W(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          start;
        int          len;
        int          nwr;
        logic        sel;
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        e_err;
        logic        e_done;
        logic        e_rdy;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q [$];
    wr_t  w;
    logic prev_we = 1'b0;

    logic [7:0] pool [0:52];
    vec_t       vt   [0:5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
            chk("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("wr_sel",  {31'd0, bus.mem_sel}, {31'd0, w.sel});
                chk("wr_addr", {22'd0, bus.mem_addr}, {22'd0, w.addr});
                chk("wr_data", bus.mem_wdata, w.data);
            end
        end
        prev_we = bus.mem_we;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"},  {31'd0, bus.rx_ready}, 32'd0);
        chk({tag, "_mem_we"},    {31'd0, bus.mem_we}, 32'd0);
        chk({tag, "_mem_sel"},   {31'd0, bus.mem_sel}, 32'd0);
        chk({tag, "_mem_addr"},  {22'd0, bus.mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_cpu_rst"},   {31'd0, cpu_rst}, 32'd1);
        chk({tag, "_done"},      {31'd0, done}, 32'd0);
        chk({tag, "_err"},       {31'd0, err}, 32'd0);
    endtask

    // Leaves the caller 1 time unit after a rising edge, loader ready.
    task automatic do_reset();
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rdy_before_edge", {31'd0, bus.rx_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rdy_after_rst", {31'd0, bus.rx_ready}, 32'd1);
    endtask

    // Present one byte after 'gap' idle cycles (junk on rx_data), wait for acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (!bus.rx_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.rx_ready) begin
            chk("rdy_wait_timeout", {31'd0, bus.rx_ready}, 32'd1);
            bus.rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        pool = '{
            8'hA0, 8'h04, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAD,
            8'hA1, 8'hFF, 8'h03, 8'h02, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11,
            8'h22, 8'h22, 8'h22, 8'h22, 8'h5F,
            8'hA0, 8'h04, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00,
            8'h55,
            8'hA1, 8'h10, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hFF,
            8'hA0, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h83, 8'hFF
        };

        //        start len nwr sel   a0         a1         d0            d1            err   done  rdy
        vt[0] = '{0,  10, 1, 1'b0, 10'h004, 10'h000, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[1] = '{10, 14, 2, 1'b1, 10'h3FF, 10'h000, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1};
        vt[2] = '{24, 10, 1, 1'b0, 10'h004, 10'h000, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vt[3] = '{34, 1,  0, 1'b0, 10'h000, 10'h000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vt[4] = '{35, 7,  0, 1'b0, 10'h000, 10'h000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vt[5] = '{42, 11, 1, 1'b0, 10'h000, 10'h000, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1, 1'b0};

        #3;

        // ---------------- table-driven frames, full-rate bytes ----------------
        for (int i = 0; i < 6; i++) begin
            do_reset();
            if (vt[i].nwr > 0) exp_q.push_back('{vt[i].sel, vt[i].a0, vt[i].d0});
            if (vt[i].nwr > 1) exp_q.push_back('{vt[i].sel, vt[i].a1, vt[i].d1});
            for (int k = 0; k < vt[i].len; k++) begin
                send_byte(pool[vt[i].start + k], 0);
            end
            // One cycle after the final byte was accepted
            chk($sformatf("v%0d_err", i),     {31'd0, err},          {31'd0, vt[i].e_err});
            chk($sformatf("v%0d_done", i),    {31'd0, done},         {31'd0, vt[i].e_done});
            chk($sformatf("v%0d_rx_ready", i), {31'd0, bus.rx_ready}, {31'd0, vt[i].e_rdy});
            chk($sformatf("v%0d_cpu_rst", i), {31'd0, cpu_rst},      {31'd0, ~vt[i].e_done});
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_writes_left", i), exp_q.size(), 32'd0);
            exp_q.delete();
            if (vt[i].nwr > 0) begin
                chk($sformatf("v%0d_addr_hold", i), {22'd0, bus.mem_addr},
                    {22'd0, (vt[i].nwr > 1) ? vt[i].a1 : vt[i].a0});
                chk($sformatf("v%0d_wdata_hold", i), bus.mem_wdata,
                    (vt[i].nwr > 1) ? vt[i].d1 : vt[i].d0);
            end
        end

        // ---------------- ERR is terminal: stream held valid is ignored ----------------
        do_reset();
        send_byte(8'h55, 0);
        bus.rx_data  = 8'hA0;
        bus.rx_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        chk("err_term_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("err_term_err",      {31'd0, err}, 32'd1);
        chk("err_term_cpu_rst",  {31'd0, cpu_rst}, 32'd1);

        // ---------------- RUN is terminal ----------------
        do_reset();
        send_byte(8'hFF, 0);
        bus.rx_data  = 8'hA1;
        bus.rx_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        chk("run_term_done",     {31'd0, done}, 32'd1);
        chk("run_term_cpu_rst",  {31'd0, cpu_rst}, 32'd0);
        chk("run_term_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("run_term_err",      {31'd0, err}, 32'd0);

        // ---------------- async reset mid-frame, random gaps ----------------
        do_reset();
        exp_q.push_back('{1'b0, 10'h008, 32'h44332211});
        send_byte(8'hA0, $urandom_range(0, 2));
        send_byte(8'h08, $urandom_range(0, 2));
        send_byte(8'h00, $urandom_range(0, 2));
        send_byte(8'h03, $urandom_range(0, 2));
        send_byte(8'h00, $urandom_range(0, 2));
        send_byte(8'h11, $urandom_range(0, 2));
        send_byte(8'h22, $urandom_range(0, 2));
        send_byte(8'h33, $urandom_range(0, 2));
        send_byte(8'h44, $urandom_range(0, 2));
        send_byte(8'h55, $urandom_range(0, 2));
        send_byte(8'h66, $urandom_range(0, 2));
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_writes_left", exp_q.size(), 32'd0);
        exp_q.delete();

        // Fresh frame after the reset loads normally
        exp_q.push_back('{1'b0, 10'h004, 32'h12345678});
        for (int k = 0; k < 10; k++) begin
            send_byte(pool[k], $urandom_range(0, 3));
        end
        chk("fresh_err",      {31'd0, err}, 32'd0);
        chk("fresh_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("fresh_writes_left", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
